// File: rtl/bloon_pkg.sv
// Purpose: shared constants, latch-FSM encoding and background address helper for bloon pixel fetch.
// Latency: n/a (package).
// Backpressure: n/a (package).
package bloon_pkg;

    localparam int BG_W  = 320;
    localparam int BG_H  = 240;
    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int PIX_W = 5;

    // Position latch FSM: wait for the vsync falling edge, then hold until vsync returns high.
    typedef enum logic [0:0] {
        WAIT_VS = 1'b0,
        LOCKED  = 1'b1
    } latch_fsm_e;

    // Background 320x240 image shown 2x upscaled: address = y_half*320 + x_half.
    // 320 = 256 + 64, so the multiply is two shifts and an add.
    function automatic logic [16:0] bg_addr_of(input logic [8:0] x_half, input logic [8:0] y_half);
        logic [16:0] y_ext;
        y_ext = {8'd0, y_half};
        return (y_ext << 8) + (y_ext << 6) + {8'd0, x_half};
    endfunction

endpackage

// File: rtl/bloon_pixel_fetch_if.sv
// Purpose: ROM-side bus of the pixel fetch (background and sprite address/data pairs).
// Latency: data is expected in the cycle after the registered address changes.
// Backpressure: none; ROMs are read every cycle.
// master: fetch logic (drives addresses, receives palette indices); slave: the ROMs.
interface bloon_pixel_fetch_if;
    import bloon_pkg::*;

    logic [16:0]      bg_addr;
    logic [PIX_W-1:0] bg_data;
    logic [9:0]       spr_addr;
    logic [PIX_W-1:0] spr_data;

    modport master (output bg_addr, output spr_addr, input bg_data, input spr_data);
    modport slave  (input bg_addr, input spr_addr, output bg_data, output spr_data);
endinterface

// File: rtl/bloon_pixel_fetch.sv
// Purpose: per-pixel background/sprite ROM fetch and transparent-key mux for the VGA bloon layer.
// Latency: 2 cycles DrawX/DrawY -> pix_index; timing signals delayed by the same 2 cycles.
// Backpressure: none; free-running pipeline that follows the VGA pixel clock every cycle.
// Ports: Clk/Reset (sync, active-high); DrawX/DrawY + blank_n/hs/vs from the VGA timing generator;
//        bloon_x/bloon_y/bloon_en sprite placement; rom = ROM bus (master side);
//        pix_index + blank_n_d/hs_d/vs_d to the palette stage.
module bloon_pixel_fetch
    import bloon_pkg::*;
#(
    parameter int               SPR_SIZE   = 32,
    parameter logic [PIX_W-1:0] TRANSP_IDX = 5'd0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    input  logic                blank_n,
    input  logic                hs,
    input  logic                vs,
    input  logic [9:0]          bloon_x,
    input  logic [9:0]          bloon_y,
    input  logic                bloon_en,
    bloon_pixel_fetch_if.master rom,
    output logic [PIX_W-1:0]    pix_index,
    output logic                blank_n_d,
    output logic                hs_d,
    output logic                vs_d
);

    localparam int         SPR_LOG    = $clog2(SPR_SIZE);
    localparam logic [0:0] ST_WAIT_VS = WAIT_VS;
    localparam logic [0:0] ST_LOCKED  = LOCKED;

    logic [0:0]       state_q, state_d;
    logic             vs_prev_q, vs_prev_d;
    logic [9:0]       bx_l_q, bx_l_d;
    logic [9:0]       by_l_q, by_l_d;
    logic             en_l_q, en_l_d;
    logic [16:0]      bg_addr_q, bg_addr_d;
    logic [9:0]       spr_addr_q, spr_addr_d;
    logic             in_spr_s1_q, in_spr_s1_d;
    logic             blank_s1_q, hs_s1_q, vs_s1_q;
    logic [PIX_W-1:0] pix_q, pix_d;
    logic             blank_d_q, hs_d_q, vs_d_q;

    logic             vs_fall;
    logic [10:0]      dx, dy;

    // Position is sampled once per frame so a mid-frame move never tears the sprite.
    assign vs_fall = vs_prev_q & ~vs;

    always_comb begin
        state_d   = state_q;
        bx_l_d    = bx_l_q;
        by_l_d    = by_l_q;
        en_l_d    = en_l_q;
        vs_prev_d = vs;
        case (state_q)
            ST_WAIT_VS: if (vs_fall) begin
                state_d = ST_LOCKED;
                bx_l_d  = bloon_x;
                by_l_d  = bloon_y;
                en_l_d  = bloon_en;
            end
            ST_LOCKED:  if (vs) state_d = ST_WAIT_VS;
            default:    state_d = ST_WAIT_VS;
        endcase
    end

    // 11-bit differences: a pixel left of/above the sprite wraps to a large unsigned value
    // and fails the range test, so there is no aliasing back into the sprite.
    always_comb begin
        dx          = {1'b0, DrawX} - {1'b0, bx_l_q};
        dy          = {1'b0, DrawY} - {1'b0, by_l_q};
        in_spr_s1_d = en_l_q && (dx < 11'(SPR_SIZE)) && (dy < 11'(SPR_SIZE));
        bg_addr_d   = bg_addr_of(DrawX[9:1], DrawY[9:1]);
        spr_addr_d  = in_spr_s1_d ? 10'({dy[SPR_LOG-1:0], dx[SPR_LOG-1:0]}) : spr_addr_q;
        pix_d       = (in_spr_s1_q && (rom.spr_data != TRANSP_IDX)) ? rom.spr_data : rom.bg_data;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_WAIT_VS;
            vs_prev_q   <= 1'b0;
            bx_l_q      <= '0;
            by_l_q      <= '0;
            en_l_q      <= 1'b0;
            bg_addr_q   <= '0;
            spr_addr_q  <= '0;
            in_spr_s1_q <= 1'b0;
            blank_s1_q  <= 1'b0;
            hs_s1_q     <= 1'b1;
            vs_s1_q     <= 1'b1;
            pix_q       <= '0;
            blank_d_q   <= 1'b0;
            hs_d_q      <= 1'b1;
            vs_d_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            vs_prev_q   <= vs_prev_d;
            bx_l_q      <= bx_l_d;
            by_l_q      <= by_l_d;
            en_l_q      <= en_l_d;
            bg_addr_q   <= bg_addr_d;
            spr_addr_q  <= spr_addr_d;
            in_spr_s1_q <= in_spr_s1_d;
            blank_s1_q  <= blank_n;
            hs_s1_q     <= hs;
            vs_s1_q     <= vs;
            pix_q       <= pix_d;
            blank_d_q   <= blank_s1_q;
            hs_d_q      <= hs_s1_q;
            vs_d_q      <= vs_s1_q;
        end
    end

    assign rom.bg_addr  = bg_addr_q;
    assign rom.spr_addr = spr_addr_q;
    assign pix_index    = pix_q;
    assign blank_n_d    = blank_d_q;
    assign hs_d         = hs_d_q;
    assign vs_d         = vs_d_q;

endmodule
